// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// one-deep valid/ready output buffer with framing-error and overrun pulses.
module uart_rx_byte #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic       UART_CTS
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t          state_r;
    logic [1:0]      sync_r;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      bit_r;
    logic [7:0]      shreg_r;
    logic [7:0]      data_r;
    logic            valid_r;
    logic            frame_err_r;
    logic            overrun_r;
    logic            busy_r;
    logic            cts_r;
    logic            rxs_s;
    logic            tick_s;

    assign rxs_s = sync_r[1];

    // Two-flop synchronizer, preset to the idle (mark) level.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], UART_RXD};
        end
    end

    // Baud tick: half a bit period from the start edge, a full bit period afterwards.
    always_comb begin
        tick_s = 1'b0;
        case (state_r)
            START:     tick_s = (cnt_r == HALF_M1);
            DATA,
            STOP:      tick_s = (cnt_r == CPB_M1);
            default:   tick_s = 1'b0;
        endcase
    end

    // Receive FSM, baud counter, output buffer and status flags.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            bit_r       <= 3'd0;
            shreg_r     <= 8'h00;
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
            cts_r       <= 1'b1;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;

            if (valid_r && rx_ready) begin
                valid_r <= 1'b0;
                cts_r   <= 1'b1;
            end

            if (state_r == IDLE || tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end

            case (state_r)
                IDLE: begin
                    if (!rxs_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (!rxs_s) begin
                            state_r <= DATA;
                            bit_r   <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shreg_r <= {rxs_s, shreg_r[7:1]};
                        bit_r   <= bit_r + 3'd1;
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (rxs_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            // A byte consumed on this same edge frees the buffer for the new one.
                            if (!valid_r || rx_ready) begin
                                data_r  <= shreg_r;
                                valid_r <= 1'b1;
                                cts_r   <= 1'b0;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BRK;
                        end
                    end
                end
                BRK: begin
                    if (rxs_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_r;
    assign rx_valid  = valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;
    assign UART_CTS  = cts_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scenario bench for uart_rx_byte: serial frames are driven on the line, expected
// bytes are queued as they are sent and popped when the receiver hands them over.
module tb_uart_rx_byte;

    localparam int CPB = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic       cts;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int vcycles  = 0;
    logic [7:0] exp_q[$];

    uart_rx_byte dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .UART_RXD (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy),
        .UART_CTS (cts)
    );

    always #10 clk = ~clk;

    // Scoreboard and flag monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid === 1'b1) vcycles++;
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            if (frame_err === 1'b1 && overrun === 1'b1) begin
                n_fail++;
                $display("FAIL flags_exclusive: frame_err=%b overrun=%b, required not both", frame_err, overrun);
            end
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                logic [7:0] e;
                beats++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got byte %02h, required no transfer", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: got %02h, required %02h", rx_data, e);
                    end
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(CPB);
        end
        rxd = stop;
        cyc(CPB);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        cyc(5);
        n_checks++;
        if ({rx_data, rx_valid, frame_err, overrun, busy, cts} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got data=%02h v=%b fe=%b ov=%b busy=%b cts=%b, required 00 0 0 0 0 1",
                     rx_data, rx_valid, frame_err, overrun, busy, cts);
        end
        rst = 1'b0;
        cyc(5);
    endtask

    task automatic test_single();
        int n, fe0, ov0, b0;
        bit seen, pulse_ok;
        logic [7:0] got;
        fe0 = fe_cnt; ov0 = ov_cnt; b0 = beats;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        n = 0; seen = 0; pulse_ok = 0; got = 8'h00;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!seen && n < 5000) begin
                    @(posedge clk); #1;
                    n++;
                    if (rx_valid === 1'b1) begin
                        seen = 1;
                        got = rx_data;
                    end
                end
                @(posedge clk); #1;
                pulse_ok = (rx_valid === 1'b0);
            end
        join
        cyc(20);
        n_checks++;
        if (!seen || n < 4124 || n > 4128) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles (seen=%0d), required 4126+-2", n, seen);
        end
        n_checks++;
        if (got !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_data: got %02h, required a5", got);
        end
        n_checks++;
        if (!pulse_ok) begin
            n_fail++;
            $display("FAIL single_pulse: rx_valid still high on second cycle, required one-cycle beat");
        end
        n_checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0 || beats - b0 != 1) begin
            n_fail++;
            $display("FAIL single_flags: got fe=%0d ov=%0d beats=%0d, required 0 0 1",
                     fe_cnt - fe0, ov_cnt - ov0, beats - b0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, fe0, ov0;
        b0 = beats; fe0 = fe_cnt; ov0 = ov_cnt;
        rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        cyc(CPB);
        n_checks++;
        if (beats - b0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_beats: got %0d beats, %0d pending, required 2 beats 0 pending",
                     beats - b0, exp_q.size());
        end
        n_checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            n_fail++;
            $display("FAIL b2b_flags: got fe=%0d ov=%0d, required 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_overrun();
        int b0, ov0, fe0;
        b0 = beats; ov0 = ov_cnt; fe0 = fe_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C || cts !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: got v=%b data=%02h cts=%b, required 1 3c 0", rx_valid, rx_data, cts);
        end
        send_byte(8'hC3, 1'b1);
        n_checks++;
        if (ov_cnt - ov0 != 1 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL ovr_pulse: got overrun=%0d fe=%0d, required 1 0", ov_cnt - ov0, fe_cnt - fe0);
        end
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C || cts !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_hold: got v=%b data=%02h cts=%b, required 1 3c 0", rx_valid, rx_data, cts);
        end
        rx_ready = 1'b1;
        cyc(4);
        n_checks++;
        if (beats - b0 != 1 || rx_valid !== 1'b0 || cts !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovr_drain: got beats=%0d v=%b cts=%b pending=%0d, required 1 0 1 0",
                     beats - b0, rx_valid, cts, exp_q.size());
        end
    endtask

    task automatic test_frame_err();
        int fe0, v0, busy_low;
        fe0 = fe_cnt; v0 = vcycles; busy_low = 0;
        rx_ready = 1'b1;
        send_byte(8'h55, 1'b0);
        for (int i = 0; i < 20 * CPB; i++) begin
            cyc(1);
            if (busy !== 1'b1) busy_low++;
        end
        n_checks++;
        if (busy_low != 0) begin
            n_fail++;
            $display("FAIL ferr_busy_hold: busy low for %0d cycles while line low, required 0", busy_low);
        end
        rxd = 1'b1;
        cyc(6);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_busy_release: got busy=%b, required 0", busy);
        end
        n_checks++;
        if (fe_cnt - fe0 != 1 || vcycles != v0) begin
            n_fail++;
            $display("FAIL ferr_pulse: got frame_err=%0d valid_cycles=%0d, required 1 0",
                     fe_cnt - fe0, vcycles - v0);
        end
        cyc(CPB);
    endtask

    task automatic test_glitch();
        int fe0, ov0, v0;
        logic busy_mid;
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcycles;
        rxd = 1'b0;
        cyc(10);
        busy_mid = busy;
        cyc(90);
        rxd = 1'b1;
        cyc(CPB);
        n_checks++;
        if (busy_mid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: got busy during=%b after=%b, required 1 0", busy_mid, busy);
        end
        n_checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0 || vcycles != v0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got fe=%0d ov=%0d valid_cycles=%0d, required 0 0 0",
                     fe_cnt - fe0, ov_cnt - ov0, vcycles - v0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic busy_before;
        int b0;
        b = 8'h81;
        b0 = beats;
        rx_ready = 1'b1;
        rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            cyc(CPB);
        end
        rxd = b[4];
        cyc(CPB / 2);
        busy_before = busy;
        rst = 1'b1;
        rxd = 1'b1;
        cyc(1);
        n_checks++;
        if (busy_before !== 1'b1 ||
            {rx_data, rx_valid, frame_err, overrun, busy, cts} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid: busy_before=%b got data=%02h v=%b fe=%b ov=%b busy=%b cts=%b, required 1 / 00 0 0 0 0 1",
                     busy_before, rx_data, rx_valid, frame_err, overrun, busy, cts);
        end
        rst = 1'b0;
        cyc(2 * CPB);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1);
        cyc(CPB);
        n_checks++;
        if (beats - b0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_deliver: got beats=%0d pending=%0d, required 1 0", beats - b0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending bytes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
